// File: rtl/tick_irq_ctrl_pkg.sv
// Shared constants and FSM encoding for the tick timer and its interrupt consumers.
// Keeps period and missed-counter widths consistent across the tick domain.
package tick_irq_ctrl_pkg;

    localparam int DEF_WIDTH  = 16;
    localparam int DEF_MISS_W = 4;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_t;

endpackage

// File: rtl/tick_irq_ctrl_sat_counter.sv
// Saturating up-counter with synchronous clear; clear beats increment.
// Registered output, one-cycle update latency, never stalls.
module sat_counter
    import tick_irq_ctrl_pkg::*;
#(
    parameter int W = DEF_MISS_W
) (
    input  logic         i_clock,
    input  logic         i_reset,
    input  logic         i_clr,
    input  logic         i_inc,
    output logic [W-1:0] o_count
);

    localparam logic [W-1:0] ONE = {{(W-1){1'b0}}, 1'b1};
    localparam logic [W-1:0] MAX = {W{1'b1}};

    logic [W-1:0] r_count;

    always_ff @(posedge i_clock) begin
        if (i_reset || i_clr) begin
            r_count <= '0;
        end else if (i_inc && (r_count != MAX)) begin
            r_count <= r_count + ONE;
        end
    end

    assign o_count = r_count;

endmodule

// File: rtl/tick_irq_ctrl.sv
// Divides the 1-in-256 tick strobe by a loaded period and raises a held level irq.
// All outputs registered, 1-clock latency from load/tick/ack; no backpressure.
module tick_irq_ctrl
    import tick_irq_ctrl_pkg::*;
#(
    parameter int WIDTH  = DEF_WIDTH,
    parameter int MISS_W = DEF_MISS_W
) (
    input  logic              i_clock,
    input  logic              i_reset,
    input  logic              i_tick,
    input  logic              i_enable,
    input  logic              i_load,
    input  logic [WIDTH-1:0]  i_period,
    input  logic              i_periodic,
    input  logic              i_irq_ack,
    output logic              o_irq,
    output logic [WIDTH-1:0]  o_count,
    output logic [MISS_W-1:0] o_missed,
    output logic              o_busy
);

    localparam logic [WIDTH-1:0] CNT_ONE = {{(WIDTH-1){1'b0}}, 1'b1};

    state_t             r_state;
    state_t             w_next_state;
    logic [WIDTH-1:0]   r_count;
    logic [WIDTH-1:0]   w_next_count;
    logic [WIDTH-1:0]   r_period_q;
    logic               r_periodic_q;
    logic               r_irq;
    logic               w_next_irq;
    logic               r_busy;
    logic               w_load_go;
    logic               w_run_tick;
    logic               w_expire;
    logic               w_miss_inc;
    logic               w_miss_clr;

    // load always wins over a same-cycle tick, so the tick path is masked by it
    assign w_load_go  = i_load && (i_period != '0);
    assign w_run_tick = (r_state == ST_RUN) && i_tick && i_enable && !i_load;
    assign w_expire   = w_run_tick && (r_count <= CNT_ONE);

    always_ff @(posedge i_clock) begin
        if (i_reset) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    always_comb begin
        w_next_state = r_state;
        if (i_load) begin
            w_next_state = w_load_go ? ST_RUN : ST_IDLE;
        end else if (w_expire && !r_periodic_q) begin
            w_next_state = ST_DONE;
        end
    end

    always_comb begin
        w_next_count = r_count;
        if (i_load) begin
            w_next_count = i_period;
        end else if (w_run_tick) begin
            if (w_expire) begin
                w_next_count = r_periodic_q ? r_period_q : '0;
            end else begin
                w_next_count = r_count - CNT_ONE;
            end
        end

        // a coincident expiry keeps irq asserted even when acknowledged
        w_next_irq = r_irq;
        if (w_expire) begin
            w_next_irq = 1'b1;
        end else if (i_irq_ack) begin
            w_next_irq = 1'b0;
        end

        w_miss_clr = i_irq_ack;
        w_miss_inc = w_expire && r_irq && !i_irq_ack;
    end

    always_ff @(posedge i_clock) begin
        if (i_reset) begin
            r_count      <= '0;
            r_irq        <= 1'b0;
            r_busy       <= 1'b0;
            r_period_q   <= '0;
            r_periodic_q <= 1'b0;
        end else begin
            r_count <= w_next_count;
            r_irq   <= w_next_irq;
            r_busy  <= (w_next_state == ST_RUN);
            if (w_load_go) begin
                r_period_q   <= i_period;
                r_periodic_q <= i_periodic;
            end
        end
    end

    sat_counter #(
        .W (MISS_W)
    ) u_missed (
        .i_clock (i_clock),
        .i_reset (i_reset),
        .i_clr   (w_miss_clr),
        .i_inc   (w_miss_inc),
        .o_count (o_missed)
    );

    assign o_irq   = r_irq;
    assign o_count = r_count;
    assign o_busy  = r_busy;

endmodule

// File: tb/tb_tick_irq_ctrl.sv
// Bench for tick_irq_ctrl: directed scenarios plus random traffic against a behavioural model.
module tb_tick_irq_ctrl;

    localparam int WIDTH    = 16;
    localparam int MISS_W   = 4;
    localparam int MISS_MAX = (1 << MISS_W) - 1;

    logic              clock;
    logic              i_reset;
    logic              i_tick;
    logic              i_enable;
    logic              i_load;
    logic [WIDTH-1:0]  i_period;
    logic              i_periodic;
    logic              i_irq_ack;
    logic              o_irq;
    logic [WIDTH-1:0]  o_count;
    logic [MISS_W-1:0] o_missed;
    logic              o_busy;

    int n_checks = 0;
    int n_errors = 0;

    // behavioural model state
    bit m_run;
    int m_count;
    int m_irq;
    int m_missed;
    int m_pq;
    bit m_pp;

    tick_irq_ctrl #(
        .WIDTH  (WIDTH),
        .MISS_W (MISS_W)
    ) dut (
        .i_clock    (clock),
        .i_reset    (i_reset),
        .i_tick     (i_tick),
        .i_enable   (i_enable),
        .i_load     (i_load),
        .i_period   (i_period),
        .i_periodic (i_periodic),
        .i_irq_ack  (i_irq_ack),
        .o_irq      (o_irq),
        .o_count    (o_count),
        .o_missed   (o_missed),
        .o_busy     (o_busy)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic chk(input string tag, input int obs, input int exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic model_step();
        bit expiry;
        expiry = 1'b0;
        if (i_reset) begin
            m_run = 1'b0; m_count = 0; m_irq = 0; m_missed = 0;
        end else begin
            if (i_load) begin
                if (i_period != 0) begin
                    m_pq = int'(i_period); m_pp = i_periodic;
                    m_count = m_pq; m_run = 1'b1;
                end else begin
                    m_run = 1'b0; m_count = 0;
                end
            end else if (m_run && i_tick && i_enable) begin
                if (m_count > 1) begin
                    m_count = m_count - 1;
                end else begin
                    expiry = 1'b1;
                    if (m_pp) m_count = m_pq;
                    else begin m_count = 0; m_run = 1'b0; end
                end
            end
            if (i_irq_ack) begin
                m_missed = 0;
                m_irq = expiry ? 1 : 0;
            end else if (expiry) begin
                if (m_irq == 1) m_missed = (m_missed < MISS_MAX) ? m_missed + 1 : MISS_MAX;
                else m_irq = 1;
            end
        end
    endtask

    // one clock: model follows the inputs seen at the edge, outputs compared #1 later
    task automatic cycle();
        @(posedge clock);
        model_step();
        #1;
        chk("irq", int'(o_irq), m_irq);
        chk("count", int'(o_count), m_count);
        chk("missed", int'(o_missed), m_missed);
        chk("busy", int'(o_busy), int'(m_run));
        i_load    = 1'b0;
        i_irq_ack = 1'b0;
        i_tick    = 1'b0;
        i_reset   = 1'b0;
    endtask

    task automatic ticks(input int n, input int gap);
        repeat (n) begin
            repeat (gap - 1) cycle();
            i_tick = 1'b1;
            cycle();
        end
    endtask

    task automatic do_load(input int p, input bit per);
        i_load = 1'b1; i_period = WIDTH'(p); i_periodic = per;
        cycle();
    endtask

    task automatic do_ack();
        i_irq_ack = 1'b1;
        cycle();
    endtask

    initial begin
        i_reset = 1'b1; i_tick = 1'b0; i_enable = 1'b1; i_load = 1'b0;
        i_period = '0; i_periodic = 1'b0; i_irq_ack = 1'b0;
        m_run = 1'b0; m_count = 0; m_irq = 0; m_missed = 0; m_pq = 0; m_pp = 1'b0;
        cycle();
        i_reset = 1'b1;
        cycle();
        chk("rst_irq", int'(o_irq), 0);
        chk("rst_count", int'(o_count), 0);
        chk("rst_missed", int'(o_missed), 0);
        chk("rst_busy", int'(o_busy), 0);

        // periodic, period 3, tick every 256 clocks
        do_load(3, 1'b1);
        chk("p3_busy", int'(o_busy), 1);
        chk("p3_count0", int'(o_count), 3);
        ticks(1, 256); chk("p3_count1", int'(o_count), 2);
        ticks(1, 256); chk("p3_count2", int'(o_count), 1);
        chk("p3_irq_before", int'(o_irq), 0);
        ticks(1, 256); chk("p3_irq", int'(o_irq), 1);
        chk("p3_reload", int'(o_count), 3);

        // one-shot, period 2
        do_ack();
        chk("ack_irq", int'(o_irq), 0);
        do_load(2, 1'b0);
        ticks(2, 256);
        chk("os_irq", int'(o_irq), 1);
        chk("os_busy", int'(o_busy), 0);
        chk("os_count", int'(o_count), 0);
        ticks(10, 256);
        chk("os_hold_irq", int'(o_irq), 1);
        chk("os_hold_count", int'(o_count), 0);
        chk("os_hold_missed", int'(o_missed), 0);

        // periodic, period 1, missed saturation
        do_ack();
        do_load(1, 1'b1);
        ticks(15, 256);
        chk("sat_14", int'(o_missed), 14);
        ticks(1, 256);
        chk("sat_15", int'(o_missed), 15);
        ticks(2, 256);
        chk("sat_hold", int'(o_missed), 15);
        do_ack();
        chk("sat_ack_irq", int'(o_irq), 0);
        chk("sat_ack_missed", int'(o_missed), 0);

        // expiry and ack together with missed = 2
        ticks(3, 16);
        chk("coinc_pre_missed", int'(o_missed), 2);
        i_tick = 1'b1; i_irq_ack = 1'b1;
        cycle();
        chk("coinc_irq", int'(o_irq), 1);
        chk("coinc_missed", int'(o_missed), 0);

        // load collides with the expiring tick
        do_ack();
        do_load(2, 1'b1);
        ticks(1, 16);
        chk("lt_count1", int'(o_count), 1);
        i_tick = 1'b1; i_load = 1'b1; i_period = WIDTH'(5); i_periodic = 1'b1;
        cycle();
        chk("lt_count", int'(o_count), 5);
        chk("lt_irq", int'(o_irq), 0);
        do_load(0, 1'b0);
        chk("stop_busy", int'(o_busy), 0);
        chk("stop_count", int'(o_count), 0);

        // enable low freezes, then reset mid-RUN
        do_load(5, 1'b1);
        ticks(1, 16);
        i_enable = 1'b0;
        ticks(3, 16);
        chk("en_frozen", int'(o_count), 4);
        i_enable = 1'b1;
        ticks(4, 16);
        chk("en_irq", int'(o_irq), 1);
        i_reset = 1'b1; i_tick = 1'b1;
        cycle();
        chk("mrst_irq", int'(o_irq), 0);
        chk("mrst_count", int'(o_count), 0);
        chk("mrst_missed", int'(o_missed), 0);
        chk("mrst_busy", int'(o_busy), 0);

        // random traffic
        for (int i = 0; i < 4000; i++) begin
            i_tick     = ($urandom_range(0, 3) == 0);
            i_enable   = ($urandom_range(0, 9) != 0);
            i_load     = ($urandom_range(0, 39) == 0);
            i_period   = WIDTH'($urandom_range(0, 4));
            i_periodic = $urandom_range(0, 1) == 1;
            i_irq_ack  = ($urandom_range(0, 29) == 0);
            i_reset    = ($urandom_range(0, 499) == 0);
            cycle();
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
